primitive_sr_bram_mtap: RTL
===========================

# primitive_sr_bram_mtap

Parametrised multi-tap circular delay line built on one inferred block RAM. It replaces chains of per-length shift registers wherever several delayed copies of one time-multiplexed operator or channel stream are needed, for example the 32-slot operator pipeline. After reset it runs a self-clearing sweep so that every tap reads zero, not stale RAM contents.

## Interface
- WIDTH, 8: data word width.
- LENGTH, 32: ring depth in entries, 2..1024; need not be a power of two.
- NTAPS, 2: number of read taps, 1..4.
- TAP0..TAP3, 1 / 8 / 16 / LENGTH: delay of each tap in CEN ticks, each 1..LENGTH; unused taps are ignored.
- INIT_CLEAR, 1: 1 = zero-fill sweep after reset; 0 = go straight to RUN.

Ports:
- i_EMUCLK  in  1  master clock; single clock domain.
- i_RST  in  1  synchronous, active-high reset.
- i_CEN_n  in  1  active-low clock enable; one "tick" = a rising edge with i_CEN_n=0.
- i_CNTRRST  in  1  realign the write pointer to 0 after this tick.
- i_WR  in  1  1 = store i_D; 0 = keep the slot's previous contents (recirculate).
- i_D  in  WIDTH  input word.
- o_Q_TAP  out  NTAPS*WIDTH  registered tap outputs; tap k occupies bits [k*WIDTH +: WIDTH].
- o_PTR  out  clog2(LENGTH)  current write pointer.
- o_WRAP  out  1  high for the tick period after the pointer returns to 0.
- o_BUSY  out  1  high while the clear sweep is in progress.

## Operation
- Reset:
  - Reset is synchronous, active-high, and overrides everything, including i_CEN_n.
  - On the reset edge: o_Q_TAP=0, o_PTR=0, o_WRAP=0, clear pointer=0.
  - The state goes to INIT if INIT_CLEAR=1, otherwise to RUN.
  - o_BUSY=INIT_CLEAR.
- State INIT:
  - Writes 0 to entry clrptr on every i_EMUCLK edge, regardless of i_CEN_n.
  - clrptr increments each edge; after the write to entry LENGTH-1 the state goes to RUN and o_BUSY becomes 0.
  - i_WR, i_D and i_CNTRRST are ignored.
  - Outputs hold 0.
- State RUN, on each tick with pointer p:
  - Write: if i_WR=1, write mem[p] <= i_D; otherwise mem[p] is unchanged.
  - Read, per tap k: read address = (p - (TAP_k-1)) mod LENGTH.
  - Forwarding: when TAP_k=1, or the read address equals p, the registered output takes the effective write value (i_WR ? i_D : mem[p]). Write-first behaviour is mandatory.
  - Pointer: p <= i_CNTRRST ? 0 : (p==LENGTH-1 ? 0 : p+1). The write on the i_CNTRRST tick still goes to the old p.
  - o_WRAP <= 1 if the next p is 0, otherwise 0.
- Sequence definition:
  - Let E_n = i_WR_n ? D_n : E_{n-LENGTH}, with E = 0 before the first tick.
  - Without i_CNTRRST, after tick n: o_Q_TAP[k] = E_{n-TAP_k+1}.
- Non-tick edges (i_CEN_n=1, RUN): all registers and memory hold.
- Reset during INIT or RUN restarts the sweep from entry 0; partially written data is discarded.
- i_CNTRRST while o_BUSY=1 is ignored. Realignment is only effective in RUN.

## Timing
- Read latency: one tick. Outputs change only on ticks, reset, or INIT.
- TAP_k = 1: the output after tick n equals E_n (forwarded).
- TAP_k = LENGTH: the output equals the value written exactly LENGTH-1 ticks earlier. That slot is read on the same tick it will next be overwritten, in read-before-overwrite order for that address only when TAP_k≠1.
- INIT lasts exactly LENGTH i_EMUCLK cycles. The first effective tick is the edge after o_BUSY falls.
- o_PTR and o_WRAP update together on each tick.
- Memory is one write port plus NTAPS synchronous read ports. The implementation may replicate the RAM per tap.

## Test plan
- Reset/clear: WIDTH=8, LENGTH=32, preload RAM with 8'hFF, pulse i_RST -> o_BUSY high for 32 clocks. Afterwards all taps read 0 for 32 ticks with i_WR=0.
- Basic delay: TAP0=1, TAP1=8, drive i_D = tick index with i_WR=1 -> after tick n, tap0 = n and tap1 = n-7 (n≥7).
- Full length: TAP=32, LENGTH=32 -> after tick 40, output = 9. o_WRAP is high after ticks 31, 63, …; o_PTR counts 0..31.
- Recirculate: write 0..31 in one lap, then i_WR=0 -> next lap tap0 (TAP=1) outputs 0..31 again, and the contents persist indefinitely.
- i_CNTRRST: assert at p=10 with i_D=8'hAA -> mem[10]=8'hAA, next o_PTR=0, o_WRAP=1. TAP=1 output after that tick = 8'hAA.
- CEN gaps and mid-run reset: insert 3 idle edges between ticks -> outputs and pointer frozen. Assert i_RST at p=17 -> pointer 0, outputs 0, full 32-cycle sweep repeats.

Source files
------------

// File: rtl/primitive_sr_bram_mtap_if.sv
// Bus bundle for the multi-tap circular delay line: tick/write controls in,
// registered taps and pointer status out.
interface primitive_sr_bram_mtap_if #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 32,
    parameter int NTAPS  = 2
);
    localparam int PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    logic                     i_CEN_n;
    logic                     i_CNTRRST;
    logic                     i_WR;
    logic [WIDTH-1:0]         i_D;
    logic [NTAPS*WIDTH-1:0]   o_Q_TAP;
    logic [PW-1:0]            o_PTR;
    logic                     o_WRAP;
    logic                     o_BUSY;

    modport master (
        output i_CEN_n, i_CNTRRST, i_WR, i_D,
        input  o_Q_TAP, o_PTR, o_WRAP, o_BUSY
    );

    modport slave (
        input  i_CEN_n, i_CNTRRST, i_WR, i_D,
        output o_Q_TAP, o_PTR, o_WRAP, o_BUSY
    );
endinterface

// File: rtl/primitive_sr_bram_mtap.sv
// Multi-tap circular delay line on one RAM array. A single write pointer walks
// the ring on every tick; each tap reads at a fixed offset behind it. After
// reset an optional sweep zero-fills the ring so no stale contents leak out.
module primitive_sr_bram_mtap #(
    parameter int WIDTH      = 8,
    parameter int LENGTH     = 32,
    parameter int NTAPS      = 2,
    parameter int TAP0       = 1,
    parameter int TAP1       = 8,
    parameter int TAP2       = 16,
    parameter int TAP3       = LENGTH,
    parameter int INIT_CLEAR = 1
) (
    input  logic                   i_EMUCLK,
    input  logic                   i_RST,
    primitive_sr_bram_mtap_if.slave bus
);
    localparam int            PW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(LENGTH - 1);

    function automatic int tap_of(input int k);
        case (k)
            0:       return TAP0;
            1:       return TAP1;
            2:       return TAP2;
            default: return TAP3;
        endcase
    endfunction

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                         state_q, state_d;
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [PW-1:0]                  clr_q, clr_d;
    logic                           wrap_q, wrap_d;
    logic                           busy_q, busy_d;
    logic [NTAPS-1:0][WIDTH-1:0]    q_q, q_d;
    logic [NTAPS-1:0][WIDTH-1:0]    rd_val;

    logic [WIDTH-1:0]               mem [LENGTH];
    logic                           mem_we;
    logic [PW-1:0]                  mem_waddr;
    logic [WIDTH-1:0]               mem_wdata;
    logic [WIDTH-1:0]               wval;

    // Value the current slot holds after this tick: new data or recirculated.
    assign wval = bus.i_WR ? bus.i_D : mem[ptr_q];

    // Per-tap read. A delay of 1 is the slot being written right now, so it
    // takes the forwarded write value (write-first). Any other delay reads an
    // older slot, which is never the write address; for delay LENGTH that is
    // the slot after p, read before it gets overwritten on the next tick.
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam int TK = tap_of(k);
        localparam int DK = TK - 1;
        if (TK == 1) begin : g_fwd
            assign rd_val[k] = wval;
        end else begin : g_rd
            logic [PW-1:0] raddr;
            // Offset subtraction modulo LENGTH without a divider.
            assign raddr = (ptr_q >= PW'(DK)) ? ptr_q - PW'(DK)
                                              : ptr_q + PW'(LENGTH - DK);
            assign rd_val[k] = mem[raddr];
        end
    end

    // Next-state: sweep in INIT, advance pointer and capture taps on ticks.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_d     = clr_q;
        wrap_d    = wrap_q;
        busy_d    = busy_q;
        q_d       = q_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = bus.i_D;
        unique case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                mem_wdata = '0;
                if (clr_q == LAST) begin
                    state_d = S_RUN;
                    busy_d  = 1'b0;
                    clr_d   = '0;
                end else begin
                    clr_d = clr_q + PW'(1);
                end
            end
            S_RUN: begin
                if (!bus.i_CEN_n) begin
                    mem_we = bus.i_WR;
                    q_d    = rd_val;
                    // The write above still lands on the old pointer.
                    ptr_d  = (bus.i_CNTRRST || ptr_q == LAST) ? '0 : ptr_q + PW'(1);
                    wrap_d = (ptr_d == '0);
                end
            end
            default: ;
        endcase
        // Reset wins over everything, including a pending RAM write.
        if (i_RST) mem_we = 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
            ptr_q   <= '0;
            clr_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= (INIT_CLEAR != 0);
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            clr_q   <= clr_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
        end
    end

    // Ring storage: one write port, no reset (the sweep clears it).
    always_ff @(posedge i_EMUCLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.o_Q_TAP = q_q;
    assign bus.o_PTR   = ptr_q;
    assign bus.o_WRAP  = wrap_q;
    assign bus.o_BUSY  = busy_q;
endmodule
